stopwatch_timebase: RTL and testbench

Timing and input front end for the stopwatch display datapath. It combines three functions:
- divides the system clock into 1/2/4/50 Hz square waves with matching one-cycle tick strobes;
- debounces the two push buttons, sampling on the 4 Hz tick;
- converts a 12-bit elapsed-seconds value into four BCD display digits (MM:SS).
The counter logic and the 7-segment multiplexer consume its outputs.

---
 rtl/stopwatch_timebase.sv | 192 +++++++++++++++++++
 tb/tb_stopwatch_timebase.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_timebase.sv
// Stopwatch timing front end: 1/2/4/50 Hz divider, 4 Hz-sampled button debouncers, seconds-to-MM:SS BCD.
// Optional macro STOPWATCH_BTN_EDGE_EN builds registered rising-edge pulses for the debounced buttons.
module stopwatch_timebase #(
    parameter int unsigned CLK_HZ      = 100000000,
    parameter int unsigned DEB_SAMPLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_s,
    input  logic        btn_r,
    input  logic [11:0] seconds,
    output logic        clk_1hz,
    output logic        clk_2hz,
    output logic        clk_4hz,
    output logic        clk_50hz,
    output logic        tick_1hz,
    output logic        tick_2hz,
    output logic        tick_4hz,
    output logic        tick_50hz,
    output logic        btn_s_db,
    output logic        btn_r_db,
    output logic        btn_s_rise,
    output logic        btn_r_rise,
    output logic [3:0]  sec_u,
    output logic [3:0]  sec_t,
    output logic [3:0]  min_u,
    output logic [3:0]  min_t
);

    localparam int unsigned CW = $clog2(CLK_HZ / 2);
    localparam logic [3:0] DEB_N = 4'(DEB_SAMPLES);

    function automatic int unsigned half_period(input int unsigned idx);
        case (idx)
            0:       return CLK_HZ / 2;
            1:       return CLK_HZ / 4;
            2:       return CLK_HZ / 8;
            default: return CLK_HZ / 100;
        endcase
    endfunction

    // Index 0..3 = 1, 2, 4, 50 Hz
    logic [3:0] sq_all;
    logic [3:0] tick_all;

    for (genvar g = 0; g < 4; g++) begin : g_div
        localparam logic [CW-1:0] LAST = CW'(half_period(g) - 1);

        logic [CW-1:0] cnt_q, cnt_d;
        logic          sq_q, sq_d;
        logic          tick_q, tick_d;

        always_comb begin
            cnt_d  = cnt_q + 1'b1;
            sq_d   = sq_q;
            tick_d = 1'b0;
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                sq_d   = ~sq_q;
                tick_d = ~sq_q;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q  <= '0;
                sq_q   <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                sq_q   <= sq_d;
                tick_q <= tick_d;
            end
        end

        assign sq_all[g]   = sq_q;
        assign tick_all[g] = tick_q;
    end

    assign clk_1hz   = sq_all[0];
    assign clk_2hz   = sq_all[1];
    assign clk_4hz   = sq_all[2];
    assign clk_50hz  = sq_all[3];
    assign tick_1hz  = tick_all[0];
    assign tick_2hz  = tick_all[1];
    assign tick_4hz  = tick_all[2];
    assign tick_50hz = tick_all[3];

    // Index 0 = btn_s, 1 = btn_r
    logic [1:0] btn_raw;
    logic [1:0] db_all;
    logic [1:0] rise_all;

    assign btn_raw = {btn_r, btn_s};

    for (genvar b = 0; b < 2; b++) begin : g_deb
        logic       meta_q, meta_d;
        logic       sync_q, sync_d;
        logic       db_q, db_d;
        logic [3:0] cnt_q, cnt_d;

        always_comb begin
            meta_d = btn_raw[b];
            sync_d = meta_q;
            db_d   = db_q;
            cnt_d  = cnt_q;
            if (tick_all[2]) begin
                if (sync_q != db_q) begin
                    if (cnt_q + 4'd1 == DEB_N) begin
                        db_d  = sync_q;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                meta_q <= 1'b0;
                sync_q <= 1'b0;
                db_q   <= 1'b0;
                cnt_q  <= '0;
            end else begin
                meta_q <= meta_d;
                sync_q <= sync_d;
                db_q   <= db_d;
                cnt_q  <= cnt_d;
            end
        end

        assign db_all[b] = db_q;

`ifdef STOPWATCH_BTN_EDGE_EN
        // Pulse lands one cycle after the debounced level rises
        logic prev_q, prev_d;
        logic rise_q, rise_d;

        always_comb begin
            prev_d = db_q;
            rise_d = db_q & ~prev_q;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                prev_q <= 1'b0;
                rise_q <= 1'b0;
            end else begin
                prev_q <= prev_d;
                rise_q <= rise_d;
            end
        end

        assign rise_all[b] = rise_q;
`else
        assign rise_all[b] = 1'b0;
`endif
    end

    assign btn_s_db   = db_all[0];
    assign btn_r_db   = db_all[1];
    assign btn_s_rise = rise_all[0];
    assign btn_r_rise = rise_all[1];

    logic [6:0]  min_val;
    logic [5:0]  sec_val;
    logic [15:0] digits_q, digits_d;

    always_comb begin
        min_val  = 7'(seconds / 12'd60);
        sec_val  = 6'(seconds % 12'd60);
        digits_d = {4'(min_val / 7'd10), 4'(min_val % 7'd10),
                    4'(sec_val / 6'd10), 4'(sec_val % 6'd10)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digits_q <= '0;
        end else begin
            digits_q <= digits_d;
        end
    end

    assign min_t = digits_q[15:12];
    assign min_u = digits_q[11:8];
    assign sec_t = digits_q[7:4];
    assign sec_u = digits_q[3:0];

endmodule

// File: tb/tb_stopwatch_timebase.sv
// Self-checking bench for stopwatch_timebase at CLK_HZ=200, DEB_SAMPLES=2.
// Honours STOPWATCH_BTN_EDGE_EN to choose the expected rise-pulse behaviour.
module tb_stopwatch_timebase;

    localparam int unsigned CLK_HZ = 200;
    localparam int unsigned DEB    = 2;
    // Half periods for 1, 2, 4, 50 Hz at 200 Hz system clock
    localparam int HP [4] = '{100, 50, 25, 2};

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_s, btn_r;
    logic [11:0] seconds;
    logic        clk_1hz, clk_2hz, clk_4hz, clk_50hz;
    logic        tick_1hz, tick_2hz, tick_4hz, tick_50hz;
    logic        btn_s_db, btn_r_db, btn_s_rise, btn_r_rise;
    logic [3:0]  sec_u, sec_t, min_u, min_t;

    stopwatch_timebase #(
        .CLK_HZ      (CLK_HZ),
        .DEB_SAMPLES (DEB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_s      (btn_s),
        .btn_r      (btn_r),
        .seconds    (seconds),
        .clk_1hz    (clk_1hz),
        .clk_2hz    (clk_2hz),
        .clk_4hz    (clk_4hz),
        .clk_50hz   (clk_50hz),
        .tick_1hz   (tick_1hz),
        .tick_2hz   (tick_2hz),
        .tick_4hz   (tick_4hz),
        .tick_50hz  (tick_50hz),
        .btn_s_db   (btn_s_db),
        .btn_r_db   (btn_r_db),
        .btn_s_rise (btn_s_rise),
        .btn_r_rise (btn_r_rise),
        .sec_u      (sec_u),
        .sec_t      (sec_t),
        .min_u      (min_u),
        .min_t      (min_t)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit sq_at(input int n, input int h);
        return ((n / h) % 2) == 1;
    endfunction

    function automatic bit tick_at(input int n, input int h);
        return (n > 0) && (n % h == 0) && ((n / h) % 2 == 1);
    endfunction

    // Model state: n = clock edges since reset released
    int         n;
    bit         started = 1'b0;
    logic [3:0] m_sq, m_tick;
    logic [1:0] m_db, m_dbp, m_rise, h1, h2;
    int         m_run [2];
    logic [15:0] m_dig;

    always @(posedge clk) begin
        logic [1:0] raw;
        bit         t4;
        int         m, s;
        started = 1'b1;
        raw = {btn_r, btn_s};
        if (rst) begin
            n = 0;
            m_db = '0; m_dbp = '0; m_rise = '0; h1 = '0; h2 = '0;
            m_run[0] = 0; m_run[1] = 0;
            m_dig = '0;
        end else begin
            t4 = tick_at(n, HP[2]);
            for (int i = 0; i < 2; i++) begin
                // sample seen by the debouncer: raw level from two edges back
                logic smp;
                smp = h2[i];
                m_rise[i] = m_db[i] & ~m_dbp[i];
                m_dbp[i]  = m_db[i];
                if (t4) begin
                    if (smp != m_db[i]) begin
                        m_run[i]++;
                        if (m_run[i] == DEB) begin
                            m_db[i]  = smp;
                            m_run[i] = 0;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
            end
            h2 = h1;
            h1 = raw;
            m = int'(seconds) / 60;
            s = int'(seconds) % 60;
            m_dig = {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
            n++;
        end
        for (int i = 0; i < 4; i++) begin
            m_sq[i]   = sq_at(n, HP[i]);
            m_tick[i] = tick_at(n, HP[i]);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("square", {clk_50hz, clk_4hz, clk_2hz, clk_1hz}, m_sq);
            chk("tick", {tick_50hz, tick_4hz, tick_2hz, tick_1hz}, m_tick);
            chk("db", {btn_r_db, btn_s_db}, m_db);
`ifdef STOPWATCH_BTN_EDGE_EN
            chk("rise", {btn_r_rise, btn_s_rise}, m_rise);
`else
            chk("rise", {btn_r_rise, btn_s_rise}, 2'b00);
`endif
            chk("digits", {min_t, min_u, sec_t, sec_u}, m_dig);
        end
    end

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    logic [15:0] sec_vec [7] = '{16'd0, 16'd59, 16'd60, 16'd599, 16'd3599, 16'd3600, 16'd4095};
    logic [15:0] dig_vec [7] = '{16'h0000, 16'h0059, 16'h0100, 16'h0959, 16'h5959, 16'h6000, 16'h6815};

    initial begin
        int k;
        rst = 1'b1; btn_s = 1'b0; btn_r = 1'b0; seconds = '0;
        step(3);
        chk("reset_state", {clk_1hz, clk_2hz, clk_4hz, clk_50hz, tick_1hz, tick_2hz, tick_4hz,
                            tick_50hz, btn_s_db, btn_r_db, min_t, min_u, sec_t, sec_u}, '0);
        rst = 1'b0;
        step(1);
        chk("c50_n1", clk_50hz, 1'b0);
        step(1);
        chk("c50_first_rise", {clk_50hz, tick_50hz}, 2'b11);
        step(23);
        chk("c4_first_rise", {clk_4hz, tick_4hz}, 2'b11);
        step(1);
        chk("t4_one_cycle", tick_4hz, 1'b0);

        for (int i = 0; i < 7; i++) begin
            seconds = sec_vec[i][11:0];
            step(1);
            chk("digits_literal", {min_t, min_u, sec_t, sec_u}, dig_vec[i]);
        end

        // short glitch well clear of any 4 Hz sample
        k = 0;
        while (tick_4hz !== 1'b1 && k < 120) begin step(1); k++; end
        chk("wait_tick4", k < 120, 1'b1);
        step(10);
        btn_s = 1'b1;
        step(5);
        btn_s = 1'b0;
        step(120);
        chk("glitch_ignored", btn_s_db, 1'b0);

        btn_r = 1'b1;
        k = 0;
        while (btn_r_db !== 1'b1 && k < 110) begin step(1); k++; end
        chk("btn_r_press_bound", k <= 103, 1'b1);
        btn_r = 1'b0;
        k = 0;
        while (btn_r_db !== 1'b0 && k < 110) begin step(1); k++; end
        chk("btn_r_release_bound", k <= 103, 1'b1);

        btn_s = 1'b1;
        k = 0;
        while (btn_s_db !== 1'b1 && k < 110) begin step(1); k++; end
        chk("btn_s_press_bound", k <= 103, 1'b1);
`ifdef STOPWATCH_BTN_EDGE_EN
        chk("rise_not_same_cycle", btn_s_rise, 1'b0);
        step(1);
        chk("rise_pulse", btn_s_rise, 1'b1);
        step(1);
        chk("rise_single", btn_s_rise, 1'b0);
`else
        step(2);
        chk("rise_tied", btn_s_rise, 1'b0);
`endif

        seconds = 12'd1234;
        step(7);
        chk("digits_1234", {min_t, min_u, sec_t, sec_u}, 16'h2034);
        rst = 1'b1;
        step(1);
        chk("mid_reset", {clk_1hz, clk_2hz, clk_4hz, clk_50hz, tick_1hz, tick_2hz, tick_4hz,
                          tick_50hz, btn_s_db, btn_r_db, btn_s_rise, btn_r_rise,
                          min_t, min_u, sec_t, sec_u}, '0);
        rst = 1'b0;
        btn_s = 1'b0;
        step(1);
        chk("restart_c50_n1", clk_50hz, 1'b0);
        step(1);
        chk("restart_c50_rise", clk_50hz, 1'b1);
        step(98);
        chk("restart_c1_rise", {clk_1hz, tick_1hz}, 2'b11);
        step(110);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
